// File: rtl/data_mem_responder.sv
// Single-port data memory slave for an RV32I core: one request in flight,
// fixed response latency, byte/half/word loads and stores with fault reporting.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemEnable,
  input  logic        MemFunc,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_30 = 30'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        func_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Request being decoded: live inputs in IDLE (only matters when LATENCY = 1),
  // the captured copy otherwise.
  logic        req_func;
  logic [2:0]  req_f3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [AW-1:0] word_idx;
  logic        f3_ok;
  logic        misaligned;
  logic        err_d;
  logic        enter_resp;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;
  logic [31:0] load_d;
  logic [31:0] rdata_d;
  logic [31:0] wword_d;
  logic [3:0]  be_d;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rdata     = rdata_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    req_func   = (state_q == IDLE) ? MemFunc : func_q;
    req_f3     = (state_q == IDLE) ? funct3  : f3_q;
    req_addr   = (state_q == IDLE) ? addr    : addr_q;
    req_wdata  = (state_q == IDLE) ? wdata   : wdata_q;
    word_idx   = req_addr[AW+1:2];
    f3_ok      = 1'b0;
    misaligned = 1'b0;
    load_d     = '0;
    wword_d    = req_wdata;
    be_d       = 4'b0000;

    if (req_func) begin
      f3_ok = (req_f3 == 3'b000) || (req_f3 == 3'b001) || (req_f3 == 3'b010) ||
              (req_f3 == 3'b100) || (req_f3 == 3'b101);
    end else begin
      f3_ok = (req_f3 == 3'b000) || (req_f3 == 3'b001) || (req_f3 == 3'b010);
    end

    unique case (req_f3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase

    err_d = !f3_ok || misaligned || (req_addr[31:2] >= DEPTH_30);

    rd_word  = mem[word_idx];
    rd_shift = rd_word >> {req_addr[1:0], 3'b000};
    rd_half  = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

    unique case (req_f3)
      3'b000:  load_d = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_d = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_d = rd_word;
      3'b100:  load_d = {24'd0, rd_shift[7:0]};
      3'b101:  load_d = {16'd0, rd_half};
      default: load_d = '0;
    endcase
    rdata_d = (req_func && !err_d) ? load_d : 32'd0;

    unique case (req_f3[1:0])
      2'b00: begin
        wword_d = {4{req_wdata[7:0]}};
        be_d    = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        wword_d = {2{req_wdata[15:0]}};
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wword_d = req_wdata;
        be_d    = 4'b1111;
      end
    endcase

    enter_resp = ((state_q == IDLE) && MemEnable && (LATENCY == 1)) ||
                 ((state_q == WAIT) && (cnt_q == 4'd0));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      func_q      <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (MemEnable) begin
            func_q  <= MemFunc;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= CNT_INIT;
            state_q <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_q <= RESP;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // The response registers are loaded on the same edge that enters RESP.
      if (enter_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= err_d;
        rdata_q     <= rdata_d;
      end else begin
        rsp_valid_q <= 1'b0;
        rsp_err_q   <= 1'b0;
        rdata_q     <= '0;
      end
    end
  end

  // NOTE: storage is deliberately left out of reset; only the control path is reset.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && !req_func && !err_d) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem[word_idx][b*8 +: 8] <= wword_d[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scenario bench for data_mem_responder: expected responses are queued at request
// time and compared when the responder strobes rsp_valid.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemEnable;
  logic        MemFunc;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb_q[$];
  bit mon_en = 1'b0;
  bit prev_valid = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .MemEnable(MemEnable), .MemFunc(MemFunc), .funct3(funct3),
    .addr(addr), .wdata(wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rdata(rdata), .rsp_err(rsp_err)
  );

  // Outputs must be quiet outside the strobe and the strobe never lasts two cycles.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (rsp_valid !== 1'b1 && (rdata !== 32'd0 || rsp_err !== 1'b0)) begin
        errors++;
        $display("FAIL quiet_outputs rdata=%h rsp_err=%b expected 00000000/0", rdata, rsp_err);
      end else if (rsp_valid === 1'b1 && prev_valid) begin
        errors++;
        $display("FAIL single_strobe rsp_valid high two cycles in a row, expected one");
      end
      prev_valid = (rsp_valid === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send(input string name, input logic func, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input bit push);
    int n;
    @(negedge clk);
    MemEnable = 1'b1; MemFunc = func; funct3 = f3; addr = a; wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_timeout req_ready=%b expected 1", name, req_ready);
      MemEnable = 1'b0;
      return;
    end
    if (push) sb_q.push_back({exp_err, exp_rd});
    @(posedge clk);
    #1;
    // Scramble the request lines: the responder must work from its captured copy.
    MemEnable = 1'b0; MemFunc = 1'b0; funct3 = 3'b010; addr = 32'h10; wdata = 32'hBAD0BAD0;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    logic [32:0] exp;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid !== 1'b1 && n < 40);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s rsp_timeout rsp_valid=%b expected 1 within 40 cycles", name, rsp_valid);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected_rsp scoreboard empty", name);
      return;
    end
    exp = sb_q.pop_front();
    checks++;
    if (rdata !== exp[31:0]) begin
      errors++;
      $display("FAIL %s rdata got %h expected %h", name, rdata, exp[31:0]);
    end
    checks++;
    if (rsp_err !== exp[32]) begin
      errors++;
      $display("FAIL %s rsp_err got %b expected %b", name, rsp_err, exp[32]);
    end
    checks++;
    if (n != LAT) begin
      errors++;
      $display("FAIL %s latency got %0d expected %0d", name, n, LAT);
    end
  endtask

  task automatic xact(input string name, input logic func, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    send(name, func, f3, a, wd, exp_rd, exp_err, 1'b1);
    wait_rsp(name);
  endtask

  task automatic test_reset();
    rst = 1'b1; MemEnable = 1'b0; MemFunc = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rdata !== 32'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state ready=%b valid=%b rdata=%h err=%b expected 1/0/00000000/0",
               req_ready, rsp_valid, rdata, rsp_err);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset ready=%b valid=%b expected 1/0", req_ready, rsp_valid);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_word();
    xact("sw_10",  1'b0, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("lw_10",  1'b1, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
  endtask

  task automatic test_byte();
    xact("sb_11",  1'b0, 3'b000, 32'h11, 32'h80, 32'h0, 1'b0);
    xact("lb_11",  1'b1, 3'b000, 32'h11, 32'h0, 32'hFFFFFF80, 1'b0);
    xact("lbu_11", 1'b1, 3'b100, 32'h11, 32'h0, 32'h00000080, 1'b0);
    xact("lw_10b", 1'b1, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);
    xact("lb_13",  1'b1, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    xact("lbu_10", 1'b1, 3'b100, 32'h10, 32'h0, 32'h000000EF, 1'b0);
  endtask

  task automatic test_half();
    xact("lh_12",  1'b1, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    xact("lhu_12", 1'b1, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 1'b0);
    xact("lh_13",  1'b1, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1);
    xact("sw_14",  1'b0, 3'b010, 32'h14, 32'h1, 32'h0, 1'b0);
    xact("sw_16",  1'b0, 3'b010, 32'h16, 32'h2, 32'h0, 1'b1);
    xact("lw_14",  1'b1, 3'b010, 32'h14, 32'h0, 32'h00000001, 1'b0);
    xact("sh_16",  1'b0, 3'b001, 32'h16, 32'h1234ABCD, 32'h0, 1'b0);
    xact("lhu_16", 1'b1, 3'b101, 32'h16, 32'h0, 32'h0000ABCD, 1'b0);
    xact("lh_16",  1'b1, 3'b001, 32'h16, 32'h0, 32'hFFFFABCD, 1'b0);
    xact("lw_14b", 1'b1, 3'b010, 32'h14, 32'h0, 32'hABCD0001, 1'b0);
  endtask

  task automatic test_errors();
    xact("lw_1000",   1'b1, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
    xact("ld_f3_011", 1'b1, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
    xact("st_f3_100", 1'b0, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("sh_15",     1'b0, 3'b001, 32'h15, 32'hFFFF, 32'h0, 1'b1);
    xact("lw_12",     1'b1, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
    xact("lw_10c",    1'b1, 3'b010, 32'h10, 32'h0, 32'hDEAD80EF, 1'b0);
    xact("sw_ffc",    1'b0, 3'b010, 32'hFFC, 32'h12345678, 32'h0, 1'b0);
    xact("lw_ffc",    1'b1, 3'b010, 32'hFFC, 32'h0, 32'h12345678, 1'b0);
  endtask

  task automatic test_reset_cancel();
    xact("sw_20_zero", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);
    send("sw_20_cancel", 1'b0, 3'b010, 32'h20, 32'h55, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL cancel_ready req_ready=%b expected 1", req_ready);
    end
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL cancel_no_rsp rsp_valid=%b expected 0", rsp_valid);
      end
    end
    xact("lw_20_after_cancel", 1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);

    @(negedge clk);
    rst = 1'b1; MemEnable = 1'b1; MemFunc = 1'b0; funct3 = 3'b010; addr = 32'h20; wdata = 32'h77;
    @(posedge clk);
    #1;
    rst = 1'b0; MemEnable = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_priority req_ready=%b expected 1", req_ready);
    end
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_priority_no_rsp rsp_valid=%b expected 0", rsp_valid);
      end
    end
    xact("lw_20_after_rst", 1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int last = -1;
    int nacc = 0;
    int nrsp = 0;
    logic [32:0] exp;
    MemEnable = 1'b1; MemFunc = 1'b1; funct3 = 3'b010; addr = 32'h10; wdata = 32'h0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 20) MemEnable = 1'b0;
      if (rsp_valid === 1'b1) begin
        nrsp++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected_rsp scoreboard empty");
        end else begin
          exp = sb_q.pop_front();
          if (rdata !== exp[31:0] || rsp_err !== exp[32]) begin
            errors++;
            $display("FAIL b2b_data got %h/%b expected %h/%b", rdata, rsp_err, exp[31:0], exp[32]);
          end
        end
      end
      if (MemEnable && req_ready === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (i - last != LAT + 1) begin
            errors++;
            $display("FAIL b2b_interval got %0d expected %0d", i - last, LAT + 1);
          end
        end
        last = i;
        nacc++;
        sb_q.push_back({1'b0, 32'hDEAD80EF});
      end
    end
    checks++;
    if (nacc != 7 || nrsp != 7) begin
      errors++;
      $display("FAIL b2b_count accepts=%0d responses=%0d expected 7/7", nacc, nrsp);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_reset_cancel();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
